// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    // Architectural zero register: reads as zero regardless of array contents.
    localparam logic [4:0] XZR_IDX   = 5'd31;
    localparam int         REG_COUNT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int            idx;
    logic [PW-1:0] idx_w;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        idx     = 0;
        idx_w   = '0;
        any     = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            idx_w = PW'(idx);
            if (req[idx_w]) begin
                grant        = '0;
                grant[idx_w] = 1'b1;
                gnt_idx      = idx_w;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one combinational register-file read port among NUM_REQ requesters
// with round-robin grant and a registered, backpressured response.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rf_addr,
    input  logic [DATA_W-1:0]         rf_data,
    output logic                      rsp_valid,
    output logic [NUM_REQ-1:0]        rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      rsp_ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       win_q, win_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]  rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       gnt_idx;
    logic                any_req;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        rf_addr_d   = rf_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                // No handshake while reset is held, so nothing is accepted then lost.
                if (any_req && !reset) begin
                    req_ready = grant;
                    win_d     = gnt_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) rf_addr_d = req_addr[i*ADDR_W +: ADDR_W];
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rsp_data_d      = (rf_addr_q == ADDR_W'(XZR_IDX)) ? '0 : rf_data;
                rsp_id_d        = '0;
                rsp_id_d[win_q] = 1'b1;
                rsp_valid_d     = 1'b1;
                state_d         = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = '0;
                    rr_ptr_d    = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            rf_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            rf_addr_q   <= rf_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed plus randomized bench for regfile_read_arbiter against a transaction-level model.
module tb_regfile_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_data;
    logic            rsp_valid;
    logic [N-1:0]    rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_ready;

    logic [DW-1:0]   rf_mem [32];

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;

    regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    assign rf_data = rf_mem[rf_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Model: first valid requester at or after the pointer, wrapping.
    function automatic int model_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // One request cycle through accept, issue, response, optional backpressure, drain.
    // scramble: 0 keep addresses, 1 set every address to 9, 2 randomize all addresses.
    task automatic txn(input logic [N-1:0] v, input int bp, input int scramble);
        int            win;
        logic [4:0]    a;
        logic [63:0]   d;
        logic [N-1:0]  oh;
        req_valid = v;
        rsp_ready = 1'b0;
        #1;
        win = model_winner(v, exp_ptr);
        if (win < 0) begin
            chk("idle_ready", req_ready, 0);
            tick();
            chk("idle_rsp_valid", rsp_valid, 0);
            return;
        end
        oh = '0;
        oh[win] = 1'b1;
        chk("accept_ready", req_ready, oh);
        a = req_addr[win*AW +: AW];
        d = (a == 5'd31) ? 64'd0 : rf_mem[a];
        tick();
        if (scramble == 1) req_addr = {N{5'd9}};
        else if (scramble == 2) req_addr = 20'($urandom);
        #1;
        chk("issue_rf_addr", rf_addr, a);
        chk("issue_ready", req_ready, 0);
        chk("issue_rsp_valid", rsp_valid, 0);
        tick();
        chk("resp_valid", rsp_valid, 1);
        chk("resp_id", rsp_id, oh);
        chk("resp_data", rsp_data, d);
        for (int c = 0; c < bp; c++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, oh);
            chk("bp_data", rsp_data, d);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ptr = (win + 1) % N;
        chk("done_valid", rsp_valid, 0);
        chk("done_id", rsp_id, 0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_req_ready", req_ready, 0);

        // Single read from requester 1.
        rf_mem[5] = 64'hDEAD_BEEF;
        set_addr(1, 5'd5);
        txn(4'b0010, 0, 0);
        chk("single_data_const", rsp_data, 64'hDEAD_BEEF);

        // Pointer now at 2: with everyone asking, 2 must win.
        txn(4'b1111, 0, 0);

        // Zero register ignores array contents.
        rf_mem[31] = '1;
        set_addr(0, 5'd31);
        txn(4'b0001, 0, 0);
        chk("xzr_data_const", rsp_data, 0);

        // Backpressure for 10 cycles while req2 waits behind req1.
        set_addr(1, 5'd12);
        set_addr(2, 5'd13);
        txn(4'b0110, 10, 0);
        txn(4'b0100, 0, 0);

        // Address change after acceptance must not affect the in-flight read.
        set_addr(3, 5'd7);
        txn(4'b1000, 0, 1);
        chk("addr_change_data", rsp_data, rf_mem[7]);

        // Reset while the response is held.
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", rsp_valid, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_rf_addr", rf_addr, 0);
        chk("mid_rst_id", rsp_id, 0);
        chk("mid_rst_ready", req_ready, 0);
        reset   = 1'b0;
        exp_ptr = 0;

        // All requesting: grants 0,1,2,3,0.
        for (int i = 0; i < 5; i++) txn(4'b1111, 0, 0);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            for (int j = 0; j < 4; j++) rf_mem[$urandom_range(0, 31)] = {$urandom, $urandom};
            req_addr = 20'($urandom);
            if ($urandom_range(0, 3) == 0) set_addr($urandom_range(0, N - 1), 5'd31);
            txn(4'($urandom_range(0, 15)), $urandom_range(0, 3), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
